// File: rtl/sha2_pkg.sv
// -----------------------------------------------------------------------------
// sha2_pkg
//   Shared definitions for the SHA-2 input control unit.
//   - Message geometry: 64-bit words, 3-bit datapath index, 8-word blocks.
//   - Controller state codes and resume codes, kept as plain logic constants
//     so they can be compared against legacy code that uses raw encodings.
// -----------------------------------------------------------------------------
package sha2_pkg;

  localparam int W             = 64;
  localparam int IDX_W         = 3;
  localparam int BLK_WORDS     = 1 << IDX_W;
  localparam int LEN_IDX       = BLK_WORDS - 1;  // length word slot
  localparam int LAST_ZERO_IDX = BLK_WORDS - 2;  // last slot that may be zero-filled

  typedef logic [2:0] state_t;
  typedef logic [1:0] resume_t;

  // Controller states
  localparam state_t S_DATA = 3'd0;  // accepting message words
  localparam state_t S_PAD  = 3'd1;  // writing the 0x80.. pad word
  localparam state_t S_ZERO = 3'd2;  // zero-filling up to the length slot
  localparam state_t S_LEN  = 3'd3;  // writing the message bit length
  localparam state_t S_FULL = 3'd4;  // block announced, waiting for blk_ack
  localparam state_t S_CLR  = 3'd5;  // one-cycle datapath clear after final block

  // Where to go once the current full block is acknowledged
  localparam resume_t R_DATA  = 2'd0;
  localparam resume_t R_ZERO  = 2'd1;
  localparam resume_t R_FINAL = 2'd2;

endpackage

// File: rtl/sha2_inctrl.sv
// -----------------------------------------------------------------------------
// sha2_inctrl
//   Control unit in front of the SHA-2 input datapath. Accepts 64-bit message
//   words over valid/ready, steers the datapath word-source selects to build
//   SHA-2 padding (pad word, zero fill, bit length), and announces each
//   complete 8-word block to the compression stage, holding until it is
//   acknowledged.
//
//   Optional build macro: SHA2_BLK_CNT_EN adds blk_cnt, the number of blocks
//   acknowledged for the current message (saturating, cleared between
//   messages).
//
// Ports
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   in_vld    in   in_pkt/in_last valid
//   in_rdy    out  word accepted when in_vld & in_rdy
//   in_pkt    in   message word
//   in_last   in   final word of the message
//   idx       in   datapath write index (datapath advances it on st_pkt)
//   pkt       out  word to datapath (in_pkt pass-through)
//   st_pkt    out  datapath write strobe
//   clr       out  datapath length/index clear
//   pad_pkt   out  select pad word
//   zero_pkt  out  select zero word
//   mgln_pkt  out  select message-length word
//   blk_vld   out  complete block available at datapath (registered)
//   blk_last  out  qualifies blk_vld: final block of message (registered)
//   blk_ack   in   block consumed
//   blk_cnt   out  [SHA2_BLK_CNT_EN only] blocks acknowledged this message
// -----------------------------------------------------------------------------
module sha2_inctrl
  import sha2_pkg::*;
#(
  parameter int W     = sha2_pkg::W,
  parameter int IDX_W = sha2_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [W-1:0]     in_pkt,
  input  logic             in_last,
  input  logic [IDX_W-1:0] idx,
  output logic [W-1:0]     pkt,
  output logic             st_pkt,
  output logic             clr,
  output logic             pad_pkt,
  output logic             zero_pkt,
  output logic             mgln_pkt,
  output logic             blk_vld,
  output logic             blk_last,
  input  logic             blk_ack
`ifdef SHA2_BLK_CNT_EN
  ,
  output logic [15:0]      blk_cnt
`endif
);

  // Slot positions derived from the index width so the controller tracks the
  // datapath geometry.
  localparam logic [IDX_W-1:0] IDX_LEN       = '1;
  localparam logic [IDX_W-1:0] IDX_LAST_ZERO = IDX_W'((1 << IDX_W) - 2);

  state_t  state, state_nxt;
  resume_t resume, resume_nxt;
  // A message whose last word lands in slot 7 still owes its pad word; it
  // becomes the first word of the following block.
  logic    pad_pend, pad_pend_nxt;

  assign pkt = in_pkt;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement leaves a value unassigned (no latches).
    state_nxt    = state;
    resume_nxt   = resume;
    pad_pend_nxt = pad_pend;
    in_rdy       = 1'b0;
    st_pkt       = 1'b0;
    clr          = 1'b0;
    pad_pkt      = 1'b0;
    zero_pkt     = 1'b0;
    mgln_pkt     = 1'b0;

    case (state)
      S_DATA: begin
        in_rdy = 1'b1;
        st_pkt = in_vld;
        if (in_vld) begin
          if (idx == IDX_LEN) begin
            state_nxt    = S_FULL;
            resume_nxt   = in_last ? R_ZERO : R_DATA;
            pad_pend_nxt = in_last;
          end else if (in_last) begin
            state_nxt = S_PAD;
          end
        end
      end

      S_PAD: begin
        st_pkt       = 1'b1;
        pad_pkt      = 1'b1;
        pad_pend_nxt = 1'b0;
        if (idx == IDX_LEN) begin
          // Pad filled the block: length goes in a fresh all-zero block.
          state_nxt  = S_FULL;
          resume_nxt = R_ZERO;
        end else if (idx == IDX_LAST_ZERO) begin
          state_nxt = S_LEN;
        end else begin
          state_nxt = S_ZERO;
        end
      end

      S_ZERO: begin
        st_pkt   = 1'b1;
        zero_pkt = 1'b1;
        if (idx == IDX_LAST_ZERO) state_nxt = S_LEN;
      end

      S_LEN: begin
        st_pkt     = 1'b1;
        mgln_pkt   = 1'b1;
        state_nxt  = S_FULL;
        resume_nxt = R_FINAL;
      end

      S_FULL: begin
        if (blk_ack) begin
          case (resume)
            R_DATA:  state_nxt = S_DATA;
            R_ZERO:  state_nxt = pad_pend ? S_PAD : S_ZERO;
            default: state_nxt = S_CLR;
          endcase
        end
      end

      S_CLR: begin
        clr       = 1'b1;
        state_nxt = S_DATA;
      end

      default: state_nxt = S_DATA;
    endcase

    // Reset forces the datapath into its cleared state and blocks all writes.
    if (rst) begin
      in_rdy   = 1'b0;
      st_pkt   = 1'b0;
      pad_pkt  = 1'b0;
      zero_pkt = 1'b0;
      mgln_pkt = 1'b0;
      clr      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (rst) begin
      state    <= S_DATA;
      resume   <= R_DATA;
      pad_pend <= 1'b0;
      blk_vld  <= 1'b0;
      blk_last <= 1'b0;
    end else begin
      state    <= state_nxt;
      resume   <= resume_nxt;
      pad_pend <= pad_pend_nxt;
      // blk_vld mirrors occupancy of S_FULL, so it rises the cycle after the
      // slot-7 write and falls the cycle after blk_ack.
      blk_vld  <= (state_nxt == S_FULL);
      blk_last <= (state_nxt == S_FULL) && (resume_nxt == R_FINAL);
    end
  end

`ifdef SHA2_BLK_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || state == S_CLR) begin
      blk_cnt <= '0;
    end else if (state == S_FULL && blk_ack && blk_cnt != 16'hFFFF) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha2_inctrl.sv
// -----------------------------------------------------------------------------
// tb_sha2_inctrl
//   Self-checking bench for sha2_inctrl. A small behavioural model of the
//   input datapath (index, length counter, 8-word block store) reacts to the
//   controller's strobes; completed blocks are compared against hand-built
//   expected blocks from a vector table. Extra sequences cover stalling in
//   S_FULL, stray blk_ack, and reset mid-padding.
// -----------------------------------------------------------------------------
module tb_sha2_inctrl;

  localparam logic [63:0] PADW = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ZW   = 64'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [63:0] in_pkt;
  logic        in_last;
  logic [2:0]  idx;
  logic [63:0] pkt;
  logic        st_pkt;
  logic        clr;
  logic        pad_pkt;
  logic        zero_pkt;
  logic        mgln_pkt;
  logic        blk_vld;
  logic        blk_last;
  logic        blk_ack;
`ifdef SHA2_BLK_CNT_EN
  logic [15:0] blk_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sha2_inctrl dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_pkt   (in_pkt),
    .in_last  (in_last),
    .idx      (idx),
    .pkt      (pkt),
    .st_pkt   (st_pkt),
    .clr      (clr),
    .pad_pkt  (pad_pkt),
    .zero_pkt (zero_pkt),
    .mgln_pkt (mgln_pkt),
    .blk_vld  (blk_vld),
    .blk_last (blk_last),
    .blk_ack  (blk_ack)
`ifdef SHA2_BLK_CNT_EN
    ,
    .blk_cnt  (blk_cnt)
`endif
  );

  // Datapath model: writes the selected word at idx, counts 64 bits per
  // data word, wraps idx naturally, clears on clr.
  logic [2:0]  dp_idx;
  logic [63:0] dp_len;
  logic [63:0] dp_mem [8];
  logic        wrote7;
  int          n_writes = 0;

  assign idx = dp_idx;

  always @(posedge clk) begin
    wrote7 <= st_pkt && !clr && (dp_idx == 3'd7);
    if (clr) begin
      dp_idx <= 3'd0;
      dp_len <= 64'd0;
    end else if (st_pkt) begin
      if (pad_pkt)       dp_mem[dp_idx] <= PADW;
      else if (zero_pkt) dp_mem[dp_idx] <= ZW;
      else if (mgln_pkt) dp_mem[dp_idx] <= dp_len;
      else begin
        dp_mem[dp_idx] <= pkt;
        dp_len         <= dp_len + 64'd64;
      end
      dp_idx   <= dp_idx + 3'd1;
      n_writes <= n_writes + 1;
    end
  end

  typedef struct {
    int              n;    // message words
    bit              two;  // message spans two blocks
    logic [7:0][63:0] b0;  // expected first block, [i] = slot i
    logic [7:0][63:0] b1;  // expected second block
  } vec_t;

  vec_t vecs [6];

  function automatic logic [63:0] dw(input int i);
    return 64'hD0D0_0000_0000_0000 | 64'(i);
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [63:0] d, input bit last);
    bit acc = 1'b0;
    in_vld  = 1'b1;
    in_pkt  = d;
    in_last = last;
    for (int t = 0; t < 20 && !acc; t++) begin
      #1 acc = in_rdy;
      @(negedge clk);
    end
    check("send_accept", 64'(acc), 64'd1);
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic run_msg(input vec_t v, input bit hold);
    int nblk = v.two ? 2 : 1;
    logic [7:0][63:0] blk;
    logic [2:0] hold_idx;
    int hold_wr;
    for (int i = 0; i < v.n; i++) send_word(dw(i), i == v.n - 1);

    for (int b = 0; b < nblk; b++) begin
      for (int t = 0; t < 40 && !(blk_vld || wrote7); t++) @(negedge clk);
      // blk_vld must rise exactly in the cycle after the slot-7 write
      check("blk_vld_timing", 64'(blk_vld && wrote7), 64'd1);
      check("blk_last", 64'(blk_last), 64'(b == nblk - 1));
`ifdef SHA2_BLK_CNT_EN
      check("blk_cnt_in_full", 64'(blk_cnt), 64'(b));
`endif
      blk = (b == 0) ? v.b0 : v.b1;
      for (int i = 0; i < 8; i++)
        check($sformatf("n%0d_b%0d_w%0d", v.n, b, i), dp_mem[i], blk[i]);

      if (hold && b == 0) begin
        hold_idx = dp_idx;
        hold_wr  = n_writes;
        in_vld   = 1'b1;
        in_pkt   = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int k = 0; k < 5; k++) begin
          #1;
          check("hold_in_rdy", 64'(in_rdy), 64'd0);
          check("hold_st_pkt", 64'(st_pkt), 64'd0);
          check("hold_blk_vld", 64'(blk_vld), 64'd1);
          @(negedge clk);
        end
        check("hold_idx", 64'(dp_idx), 64'(hold_idx));
        check("hold_writes", 64'(n_writes), 64'(hold_wr));
        in_vld = 1'b0;
      end

      blk_ack = 1'b1;
      @(negedge clk);
      blk_ack = 1'b0;
    end

    // Clear cycle after the final block's acknowledge
    #1;
    check("clr_cycle_clr", 64'(clr), 64'd1);
    check("clr_cycle_in_rdy", 64'(in_rdy), 64'd0);
    check("clr_cycle_st_pkt", 64'(st_pkt), 64'd0);
    check("clr_cycle_blk_vld", 64'(blk_vld), 64'd0);
`ifdef SHA2_BLK_CNT_EN
    check("blk_cnt_clr_cycle", 64'(blk_cnt), 64'(nblk));
`endif
    @(negedge clk);
    #1;
    check("post_clr_clr", 64'(clr), 64'd0);
    check("post_clr_in_rdy", 64'(in_rdy), 64'd1);
    check("post_clr_idx", 64'(dp_idx), 64'd0);
`ifdef SHA2_BLK_CNT_EN
    check("blk_cnt_post_clr", 64'(blk_cnt), 64'd0);
`endif
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr;

    vecs[0] = '{n: 1, two: 1'b0,
                b0: {64'h40, ZW, ZW, ZW, ZW, ZW, PADW, dw(0)}, b1: '0};
    vecs[1] = '{n: 3, two: 1'b0,
                b0: {64'hC0, ZW, ZW, ZW, PADW, dw(2), dw(1), dw(0)}, b1: '0};
    vecs[2] = '{n: 5, two: 1'b0,
                b0: {64'h140, ZW, PADW, dw(4), dw(3), dw(2), dw(1), dw(0)}, b1: '0};
    vecs[3] = '{n: 6, two: 1'b0,
                b0: {64'h180, PADW, dw(5), dw(4), dw(3), dw(2), dw(1), dw(0)}, b1: '0};
    vecs[4] = '{n: 7, two: 1'b1,
                b0: {PADW, dw(6), dw(5), dw(4), dw(3), dw(2), dw(1), dw(0)},
                b1: {64'h1C0, ZW, ZW, ZW, ZW, ZW, ZW, ZW}};
    vecs[5] = '{n: 8, two: 1'b1,
                b0: {dw(7), dw(6), dw(5), dw(4), dw(3), dw(2), dw(1), dw(0)},
                b1: {64'h200, ZW, ZW, ZW, ZW, ZW, ZW, PADW}};

    rst     = 1'b1;
    in_vld  = 1'b0;
    in_pkt  = '0;
    in_last = 1'b0;
    blk_ack = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_clr", 64'(clr), 64'd1);
    check("rst_in_rdy", 64'(in_rdy), 64'd0);
    check("rst_st_pkt", 64'(st_pkt), 64'd0);
    check("rst_blk_vld", 64'(blk_vld), 64'd0);
    check("rst_blk_last", 64'(blk_last), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("idle_in_rdy", 64'(in_rdy), 64'd1);
    check("idle_clr", 64'(clr), 64'd0);

    // Stray acknowledge outside S_FULL has no effect
    blk_ack = 1'b1;
    @(negedge clk);
    blk_ack = 1'b0;
    #1;
    check("stray_ack_blk_vld", 64'(blk_vld), 64'd0);
    check("stray_ack_in_rdy", 64'(in_rdy), 64'd1);
    check("stray_ack_idx", 64'(dp_idx), 64'd0);
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_msg(vecs[i], vecs[i].n == 7);

    // Reset in the middle of zero fill abandons the block
    send_word(dw(0), 1'b0);
    send_word(dw(1), 1'b0);
    send_word(dw(2), 1'b1);
    #1;
    check("mid_pad_sel", 64'(pad_pkt), 64'd1);
    check("mid_pad_idx", 64'(dp_idx), 64'd3);
    @(negedge clk);
    #1;
    check("mid_zero_sel", 64'(zero_pkt), 64'd1);
    check("mid_zero_idx", 64'(dp_idx), 64'd4);
    rst = 1'b1;
    #1;
    check("mid_rst_clr", 64'(clr), 64'd1);
    check("mid_rst_st_pkt", 64'(st_pkt), 64'd0);
    check("mid_rst_zero", 64'(zero_pkt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("after_rst_blk_vld", 64'(blk_vld), 64'd0);
    check("after_rst_in_rdy", 64'(in_rdy), 64'd1);
    check("after_rst_idx", 64'(dp_idx), 64'd0);
    wr = n_writes;
    repeat (10) @(negedge clk);
    check("after_rst_no_writes", 64'(n_writes), 64'(wr));
    check("after_rst_no_blk", 64'(blk_vld), 64'd0);

    // Clean message after the abandoned one
    run_msg(vecs[1], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
